// File: rtl/i2c_xfer_seq.sv
// Register-level I2C transaction sequencer: turns one host write/read request into
// the START / WR / RESTART / RD / STOP command stream for a byte-level I2C master.
module i2c_xfer_seq #(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rnw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       tmo,
    output logic [7:0] rdata,
    output logic [2:0] i2c_cmd,
    output logic [7:0] i2c_din,
    output logic       i2c_wr,
    input  logic       i2c_ready,
    input  logic       i2c_done_tick,
    input  logic       i2c_ack,
    input  logic [7:0] i2c_dout
);

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACC,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t         state_reg;
    logic [2:0]     step_reg;
    logic [CW-1:0]  wait_cnt_reg;
    logic           rnw_reg;
    logic [6:0]     dev_reg;
    logic [7:0]     reg_addr_reg;
    logic [7:0]     wdata_reg;
    logic           ack_cap_reg;
    logic [7:0]     dout_cap_reg;

    logic [2:0]     step_cmd;
    logic [7:0]     step_din;
    logic [2:0]     last_step;
    logic           timeout_hit;

    // Command/byte for the current step; the STOP step is the last one of each sequence.
    always_comb begin
        step_cmd = CMD_STOP;
        step_din = 8'h00;
        if (rnw_reg) begin
            case (step_reg)
                3'd0: step_cmd = CMD_START;
                3'd1: begin step_cmd = CMD_WR;  step_din = {dev_reg, 1'b0}; end
                3'd2: begin step_cmd = CMD_WR;  step_din = reg_addr_reg;    end
                3'd3: step_cmd = CMD_RESTART;
                3'd4: begin step_cmd = CMD_WR;  step_din = {dev_reg, 1'b1}; end
                3'd5: begin step_cmd = CMD_RD;  step_din = 8'h01;           end
                default: step_cmd = CMD_STOP;
            endcase
        end else begin
            case (step_reg)
                3'd0: step_cmd = CMD_START;
                3'd1: begin step_cmd = CMD_WR; step_din = {dev_reg, 1'b0}; end
                3'd2: begin step_cmd = CMD_WR; step_din = reg_addr_reg;    end
                3'd3: begin step_cmd = CMD_WR; step_din = wdata_reg;       end
                default: step_cmd = CMD_STOP;
            endcase
        end
    end

    assign last_step   = rnw_reg ? 3'd6 : 3'd4;
    assign timeout_hit = (wait_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            step_reg     <= 3'd0;
            wait_cnt_reg <= '0;
            rnw_reg      <= 1'b0;
            dev_reg      <= 7'd0;
            reg_addr_reg <= 8'd0;
            wdata_reg    <= 8'd0;
            ack_cap_reg  <= 1'b0;
            dout_cap_reg <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            nack         <= 1'b0;
            tmo          <= 1'b0;
            rdata        <= 8'd0;
            i2c_cmd      <= CMD_START;
            i2c_din      <= 8'd0;
            i2c_wr       <= 1'b0;
        end else begin
            i2c_wr       <= 1'b0;
            done         <= 1'b0;
            wait_cnt_reg <= wait_cnt_reg + CW'(1);

            case (state_reg)
                IDLE: begin
                    wait_cnt_reg <= '0;
                    // A request in the done cycle is dropped so IDLE always lasts a cycle.
                    if (req && !done) begin
                        rnw_reg      <= rnw;
                        dev_reg      <= dev_addr;
                        reg_addr_reg <= reg_addr;
                        wdata_reg    <= wdata;
                        step_reg     <= 3'd0;
                        busy         <= 1'b1;
                        nack         <= 1'b0;
                        tmo          <= 1'b0;
                        state_reg    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (i2c_ready) begin
                        i2c_cmd      <= step_cmd;
                        i2c_din      <= step_din;
                        i2c_wr       <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT_ACC;
                    end else if (timeout_hit) begin
                        tmo       <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                WAIT_ACC: begin
                    if (!i2c_ready) begin
                        ack_cap_reg  <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT_DONE;
                    end else if (timeout_hit) begin
                        tmo       <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                WAIT_DONE: begin
                    if (i2c_done_tick) begin
                        ack_cap_reg  <= i2c_ack;
                        dout_cap_reg <= i2c_dout;
                    end
                    if (i2c_ready) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= NEXT;
                    end else if (timeout_hit) begin
                        tmo       <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                NEXT: begin
                    wait_cnt_reg <= '0;
                    if (step_reg == last_step) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (step_cmd == CMD_WR && ack_cap_reg) begin
                        // Unacknowledged byte: skip the rest and close the bus.
                        nack      <= 1'b1;
                        step_reg  <= last_step;
                        state_reg <= ISSUE;
                    end else begin
                        if (step_cmd == CMD_RD) begin
                            rdata <= dout_cap_reg;
                        end
                        step_reg  <= step_reg + 3'd1;
                        state_reg <= ISSUE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Scoreboard bench for i2c_xfer_seq: a behavioural byte-level master answers strobes,
// expected commands and results are queued at request time and popped as the DUT acts.
module tb_i2c_xfer_seq;

    localparam int TIMEOUT = 20;

    localparam logic [2:0] C_START   = 3'b000;
    localparam logic [2:0] C_WR      = 3'b001;
    localparam logic [2:0] C_RD      = 3'b010;
    localparam logic [2:0] C_STOP    = 3'b011;
    localparam logic [2:0] C_RESTART = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       rnw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       nack;
    logic       tmo;
    logic [7:0] rdata;
    logic [2:0] i2c_cmd;
    logic [7:0] i2c_din;
    logic       i2c_wr;
    logic       i2c_ready;
    logic       i2c_done_tick;
    logic       i2c_ack;
    logic [7:0] i2c_dout;

    typedef struct packed {
        logic       nack;
        logic       tmo;
        logic [7:0] rdata;
    } res_t;

    logic [10:0] exp_cmd_q[$];
    res_t        res_q[$];
    logic [7:0]  exp_rdata = 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int n_strobes = 0;

    // master model controls
    int         nack_at = 0;
    logic [7:0] rd_byte = 8'h00;
    bit         stall = 1'b0;

    i2c_xfer_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .rnw(rnw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
        .busy(busy), .done(done), .nack(nack), .tmo(tmo), .rdata(rdata),
        .i2c_cmd(i2c_cmd), .i2c_din(i2c_din), .i2c_wr(i2c_wr),
        .i2c_ready(i2c_ready), .i2c_done_tick(i2c_done_tick),
        .i2c_ack(i2c_ack), .i2c_dout(i2c_dout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference sequence for one request, truncated to STOP after a NACKed write byte.
    task automatic push_xfer(input logic r, input logic [6:0] d, input logic [7:0] ra,
                             input logic [7:0] wd, input int nk, input logic [7:0] rb);
        logic [10:0] seq[$];
        int   wr_n = 0;
        bit   nacked = 1'b0;
        res_t e;
        seq.push_back({C_START, 8'h00});
        seq.push_back({C_WR, d, 1'b0});
        seq.push_back({C_WR, ra});
        if (!r) begin
            seq.push_back({C_WR, wd});
        end else begin
            seq.push_back({C_RESTART, 8'h00});
            seq.push_back({C_WR, d, 1'b1});
            seq.push_back({C_RD, 8'h01});
        end
        foreach (seq[i]) begin
            exp_cmd_q.push_back(seq[i]);
            if (seq[i][10:8] == C_WR) begin
                wr_n++;
                if (wr_n == nk) begin
                    nacked = 1'b1;
                    break;
                end
            end
        end
        exp_cmd_q.push_back({C_STOP, 8'h00});
        if (r && !nacked) exp_rdata = rb;
        e.nack  = nacked;
        e.tmo   = 1'b0;
        e.rdata = exp_rdata;
        res_q.push_back(e);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (!done) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_xfer(input logic r, input logic [6:0] d, input logic [7:0] ra,
                            input logic [7:0] wd, input int nk, input logic [7:0] rb,
                            input bit hold);
        nack_at = nk;
        rd_byte = rb;
        push_xfer(r, d, ra, wd, nk, rb);
        @(negedge clk);
        req = 1'b1; rnw = r; dev_addr = d; reg_addr = ra; wdata = wd;
        @(negedge clk);
        check_val("busy_after_req", busy, 1);
        if (!hold) req = 1'b0;
        wait_done(2000);
        if (hold) begin
            @(negedge clk);
            req = 1'b0;
        end
        repeat (4) @(negedge clk);
        check_val("busy_idle", busy, 0);
    endtask

    // Behavioural byte master: drop ready on a strobe, tick for WR/RD, then ready again.
    initial begin
        logic [2:0] cmd;
        int         wr_idx = 0;
        i2c_ready = 1'b1; i2c_done_tick = 1'b0; i2c_ack = 1'b0; i2c_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (i2c_wr) begin
                cmd = i2c_cmd;
                i2c_ready = 1'b0;
                if (cmd == C_START) wr_idx = 0;
                if (cmd == C_START && stall) begin
                    while (stall) @(negedge clk);
                    i2c_ready = 1'b1;
                end else begin
                    @(negedge clk);
                    @(negedge clk);
                    if (cmd == C_WR || cmd == C_RD) begin
                        if (cmd == C_WR) begin
                            wr_idx++;
                            i2c_ack  = (wr_idx == nack_at);
                            i2c_dout = 8'hEE;
                        end else begin
                            i2c_ack  = 1'b1;
                            i2c_dout = rd_byte;
                        end
                        i2c_done_tick = 1'b1;
                        @(negedge clk);
                        i2c_done_tick = 1'b0;
                    end
                    i2c_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: strobes and done pulses are checked against the scoreboard queues.
    initial begin
        logic       prev_wr = 1'b0;
        logic       prev_done = 1'b0;
        logic [10:0] ec;
        res_t       er;
        forever begin
            @(negedge clk);
            if (prev_wr) check_val("wr_back_to_back", i2c_wr, 0);
            if (prev_done) check_val("done_pulse_width", done, 0);
            if (i2c_wr) begin
                n_strobes++;
                if (exp_cmd_q.size() == 0) begin
                    check_val("extra_strobe", {i2c_cmd, i2c_din}, 32'h7FF);
                end else begin
                    ec = exp_cmd_q.pop_front();
                    check_val("cmd_din", {i2c_cmd, i2c_din}, ec);
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    check_val("extra_done", done, 0);
                end else begin
                    er = res_q.pop_front();
                    check_val("nack", nack, er.nack);
                    check_val("tmo", tmo, er.tmo);
                    check_val("rdata", rdata, er.rdata);
                    check_val("cmds_left", exp_cmd_q.size(), 0);
                end
            end
            prev_wr   = i2c_wr;
            prev_done = done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   base;
        res_t e;
        rst = 1'b1; req = 1'b0; rnw = 1'b0;
        dev_addr = 7'd0; reg_addr = 8'd0; wdata = 8'd0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_wr", i2c_wr, 0);
        check_val("rst_cmd", i2c_cmd, C_START);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_xfer(1'b0, 7'h50, 8'h0B, 8'h0C, 0, 8'h00, 1'b0);   // clean write
        run_xfer(1'b1, 7'h50, 8'h0C, 8'h00, 0, 8'h5A, 1'b0);   // clean read
        run_xfer(1'b0, 7'h50, 8'h0B, 8'h0C, 1, 8'h00, 1'b0);   // NACK on address

        // master never returns ready after START
        stall = 1'b1;
        nack_at = 0;
        exp_cmd_q.push_back({C_START, 8'h00});
        e.nack = 1'b0; e.tmo = 1'b1; e.rdata = exp_rdata;
        res_q.push_back(e);
        @(negedge clk);
        req = 1'b1; rnw = 1'b0; dev_addr = 7'h22; reg_addr = 8'h10; wdata = 8'h99;
        @(negedge clk);
        req = 1'b0;
        k = 0;
        while (!i2c_wr && k < 100) begin @(negedge clk); k++; end
        check_val("tmo_start_seen", i2c_wr, 1);
        k = 0;
        while (!done && k < TIMEOUT + 50) begin @(negedge clk); k++; end
        check_val("tmo_latency", k, TIMEOUT + 1);
        stall = 1'b0;
        repeat (4) @(negedge clk);

        run_xfer(1'b1, 7'h3A, 8'h81, 8'h00, 0, 8'hC3, 1'b0);   // read after abort

        // reset during the register-address byte
        nack_at = 0;
        push_xfer(1'b0, 7'h50, 8'h0B, 8'h0C, 0, 8'h00);
        base = n_strobes;
        @(negedge clk);
        req = 1'b1; rnw = 1'b0; dev_addr = 7'h50; reg_addr = 8'h0B; wdata = 8'h0C;
        @(negedge clk);
        req = 1'b0;
        k = 0;
        while (n_strobes < base + 3 && k < 200) begin @(negedge clk); k++; end
        check_val("rst_step_reached", n_strobes - base, 3);
        rst = 1'b1;
        @(negedge clk);
        exp_cmd_q.delete();
        res_q.delete();
        exp_rdata = 8'h00;
        check_val("arst_busy", busy, 0);
        check_val("arst_nack", nack, 0);
        check_val("arst_tmo", tmo, 0);
        check_val("arst_rdata", rdata, 0);
        check_val("arst_cmd", i2c_cmd, C_START);
        check_val("arst_din", i2c_din, 0);
        check_val("arst_wr", i2c_wr, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_val("post_rst_idle", busy, 0);

        run_xfer(1'b0, 7'h50, 8'h0B, 8'h0C, 0, 8'h00, 1'b0);   // clean write after reset
        run_xfer(1'b0, 7'h11, 8'h22, 8'h33, 0, 8'h00, 1'b1);   // req held high throughout
        run_xfer(1'b1, 7'h7F, 8'hFE, 8'h00, 0, 8'h3C, 1'b0);   // final read
        run_xfer(1'b1, 7'h12, 8'h34, 8'h00, 3, 8'h77, 1'b0);   // NACK on read re-address

        repeat (5) @(negedge clk);
        check_val("sb_cmds_drained", exp_cmd_q.size(), 0);
        check_val("sb_res_drained", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 Parameter: TIMEOUT, default 4096, cycles allowed in any single wait state before abort.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock, all logic rising-edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req  in  1  host transaction request, sampled only in IDLE.
REQ-006 rnw  in  1  1 = register read, 0 = register write, sampled with req.
REQ-007 dev_addr  in  7  7-bit target address, sampled with req.
REQ-008 reg_addr  in  8  target register index, sampled with req.
REQ-009 wdata  in  8  write data, sampled with req.
REQ-010 busy  out  1  high from the cycle after req is accepted until done.
REQ-011 done  out  1  one-cycle pulse at transaction end.
REQ-012 nack  out  1  valid with done; a WR byte was not acknowledged.
REQ-013 tmo  out  1  valid with done; a wait exceeded TIMEOUT.
REQ-014 rdata  out  8  read byte, valid with done when rnw=1 and nack=tmo=0.
REQ-015 i2c_cmd  out  3  command to master: START 000, WR 001, RD 010, STOP 011, RESTART 100.
REQ-016 i2c_din  out  8  byte to master; for RD, bit0=1 requests master NACK (last byte).
REQ-017 i2c_wr  out  1  one-cycle command strobe to master.
REQ-018 i2c_ready  in  1  master idle and able to accept a command.
REQ-019 i2c_done_tick  in  1  master one-cycle pulse at end of a WR/RD byte.
REQ-020 i2c_ack  in  1  slave ack bit, valid with i2c_done_tick (0 = ACK).
REQ-021 i2c_dout  in  8  received byte, valid with i2c_done_tick.

Function
REQ-022 Write sequence SHALL be: START, WR {dev_addr,0}, WR reg_addr, WR wdata, STOP.
REQ-023 Read sequence SHALL be: START, WR {dev_addr,0}, WR reg_addr, RESTART, WR {dev_addr,1}, RD din=8'h01, STOP.
REQ-024 FSM states: IDLE, ISSUE, WAIT_ACC, WAIT_DONE, NEXT; a step counter (0..6) selects cmd/din.
REQ-025 IDLE: req=1 latches rnw/dev_addr/reg_addr/wdata, step=0, goes to ISSUE; busy high next cycle.
REQ-026 ISSUE: when i2c_ready=1, drive i2c_cmd/i2c_din and pulse i2c_wr for exactly one cycle, go WAIT_ACC.
REQ-027 i2c_cmd/i2c_din SHALL stay stable from the strobe cycle until the step advances.
REQ-028 WAIT_ACC: wait for i2c_ready=0 (command accepted), then WAIT_DONE.
REQ-029 WAIT_DONE: wait for i2c_ready=1; for WR/RD, capture i2c_ack/i2c_dout on i2c_done_tick in this state.
REQ-030 NEXT: advance step; after final STOP completes, pulse done, clear busy, return IDLE.
REQ-031 WR completing with captured ack=1 SHALL set nack and jump directly to the STOP step; remaining bytes skipped.
REQ-032 A wait counter SHALL reset on every state entry; reaching TIMEOUT in ISSUE/WAIT_ACC/WAIT_DONE sets tmo, pulses done, returns IDLE with no STOP issued.
REQ-033 req while busy SHALL be ignored; req and done in the same cycle SHALL not start a new transaction (one IDLE cycle minimum).
REQ-034 nack/tmo/rdata SHALL hold until the next accepted req, which clears nack and tmo.
REQ-035 i2c_wr SHALL never be high on two consecutive cycles.

Reset
REQ-036 On rst: state IDLE, step 0, busy=0, done=0, nack=0, tmo=0, rdata=0, i2c_wr=0, i2c_cmd=START, i2c_din=0.
REQ-037 rst mid-transaction SHALL abort immediately with no done pulse and no further strobes after release.

Verification
REQ-038 Write dev=0x50 reg=0x0B data=0x0C, slave ACKs -> strobes START, WR A0, WR 0B, WR 0C, STOP; done with nack=0, tmo=0.
REQ-039 Read dev=0x50 reg=0x0C, slave returns 0x5A -> START, WR A0, WR 0C, RESTART, WR A1, RD 01, STOP; rdata=0x5A.
REQ-040 Write with ack=1 on the address byte -> next command is STOP, done with nack=1, no reg/data bytes sent.
REQ-041 Master model holds i2c_ready=0 forever after START -> done with tmo=1 after TIMEOUT cycles, no STOP.
REQ-042 rst asserted during WR reg_addr step -> all outputs at reset values; a new req after release runs a clean sequence.
REQ-043 req pulsed every cycle during a transaction -> exactly one done per accepted req; no i2c_wr back-to-back.
